// File: rtl/nibble_serializer_pkg.sv
// Shared definitions for the nibble serializer and the 4-bit bus stage it feeds.
package nibble_bus_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Counter width for a word of n nibbles; at least one bit even when n == 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_serializer_if.sv
// Producer/consumer signal bundle for the nibble serializer.
interface nibble_serializer_if
  import nibble_bus_pkg::*;
#(
  parameter int unsigned WORD_NIBBLES = 2
) ();

  logic [NIBBLE_W*WORD_NIBBLES-1:0] in_data;
  logic                             in_valid;
  logic                             in_ready;
  logic                             hold;
  logic [NIBBLE_W-1:0]              nib_data;
  logic                             nib_valid;
  logic                             nib_last;

  modport master (
    output in_data, in_valid, hold,
    input  in_ready, nib_data, nib_valid, nib_last
  );

  modport slave (
    input  in_data, in_valid, hold,
    output in_ready, nib_data, nib_valid, nib_last
  );

endinterface

// File: rtl/nibble_serializer.sv
// Splits WORD_NIBBLES-wide words into a registered stream of 4-bit nibbles,
// one per clock, with a valid/ready word input and a hold-driven bubble input.
module nibble_serializer
  import nibble_bus_pkg::*;
#(
  parameter int unsigned WORD_NIBBLES = 2,
  parameter bit          MSB_FIRST    = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  nibble_serializer_if.slave  bus
);

  localparam int unsigned      IN_W     = NIBBLE_W * WORD_NIBBLES;
  localparam int unsigned      CNT_W    = cnt_width(WORD_NIBBLES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_NIBBLES - 1);

  ser_state_t          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [IN_W-1:0]     r_shift;
  logic [NIBBLE_W-1:0] r_nib_data;
  logic                r_nib_valid;
  logic                r_nib_last;

  logic                w_word_done;
  logic                w_ready;
  logic                w_accept;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [NIBBLE_W-1:0] w_first;
  logic [NIBBLE_W-1:0] w_next;
  logic [IN_W-1:0]     w_load_rest;
  logic [IN_W-1:0]     w_shift_rest;

  // The first nibble goes straight from in_data to the output; the shift
  // register only holds the nibbles still to be sent, aligned to the emit end.
  if (MSB_FIRST) begin : g_msb_first
    assign w_first      = bus.in_data[IN_W-1 -: NIBBLE_W];
    assign w_next       = r_shift[IN_W-1 -: NIBBLE_W];
    assign w_load_rest  = bus.in_data << NIBBLE_W;
    assign w_shift_rest = r_shift << NIBBLE_W;
  end else begin : g_lsb_first
    assign w_first      = bus.in_data[NIBBLE_W-1:0];
    assign w_next       = r_shift[NIBBLE_W-1:0];
    assign w_load_rest  = bus.in_data >> NIBBLE_W;
    assign w_shift_rest = r_shift >> NIBBLE_W;
  end

  assign w_word_done = (r_state == IDLE) || (r_cnt == LAST_IDX);
  assign w_ready     = !bus.hold && w_word_done;
  assign w_accept    = bus.in_valid && w_ready;
  assign w_cnt_nxt   = r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_nib_data  <= '0;
      r_nib_valid <= 1'b0;
      r_nib_last  <= 1'b0;
    end else if (bus.hold) begin
      r_nib_valid <= 1'b0;
      r_nib_last  <= 1'b0;
    end else if (w_accept) begin
      r_state     <= SHIFT;
      r_cnt       <= '0;
      r_shift     <= w_load_rest;
      r_nib_data  <= w_first;
      r_nib_valid <= 1'b1;
      r_nib_last  <= (WORD_NIBBLES == 1);
    end else if (!w_word_done) begin
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_rest;
      r_nib_data  <= w_next;
      r_nib_valid <= 1'b1;
      r_nib_last  <= (w_cnt_nxt == LAST_IDX);
    end else begin
      r_state     <= IDLE;
      r_nib_valid <= 1'b0;
      r_nib_last  <= 1'b0;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.nib_data  = r_nib_data;
  assign bus.nib_valid = r_nib_valid;
  assign bus.nib_last  = r_nib_last;

endmodule
